riscv_regfile_wb_arb: RTL and testbench
=======================================

# riscv_regfile_wb_arb

Write-port arbiter for the RV32I register file. Two writeback sources share the single regfile write port (`i_regfile_rd_addr`/`_data`/`_wen`):

- source 0: the single-cycle ALU path.
- source 1: the load/multi-cycle path.

Source 0 has fixed priority, with a starvation counter that guarantees source 1 forward progress. The output is registered and drives the regfile write port directly.

## Interface
- `P_STARVE_MAX`, default 3: number of consecutive losing cycles source 1 may accumulate before it is forced a grant; legal range 1–15.
- `XLEN` comes from the shared `` `XLEN`` define (32); it is not a parameter.

Ports:
- `i_clk` in 1: system clock, all state on rising edge.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_wb0_valid` in 1: source 0 write request.
- `o_wb0_ready` out 1: source 0 granted this cycle.
- `i_wb0_addr` in 5: source 0 destination register.
- `i_wb0_data` in XLEN: source 0 write data.
- `i_wb1_valid` in 1: source 1 write request.
- `o_wb1_ready` out 1: source 1 granted this cycle.
- `i_wb1_addr` in 5: source 1 destination register.
- `i_wb1_data` in XLEN: source 1 write data.
- `o_regfile_rd_wen` out 1: regfile write enable, registered.
- `o_regfile_rd_addr` out 5: regfile write address, registered.
- `o_regfile_rd_data` out XLEN: regfile write data, registered.
- `o_starve_cnt` out 4: current starvation count (debug/verification visibility).

## Operation
- Handshake is valid/ready. A transfer occurs at a rising edge with valid && ready.
- Once valid is asserted, the source holds valid, addr and data stable until the transfer.
- Ready is combinational from the valids and the starvation count. At most one ready is high per cycle.
- Grant rules:
  - Only one source valid: that source is granted.
  - Both valid and `starve_cnt` < `P_STARVE_MAX`: source 0 is granted.
  - Both valid and `starve_cnt` == `P_STARVE_MAX`: source 1 is granted.
  - Neither valid: no grant.
- Starvation counter, 4 bits, saturating:
  - Increments when `i_wb1_valid` && !`o_wb1_ready`.
  - Clears to 0 when source 1 transfers, or when `i_wb1_valid` is low.
  - Never exceeds `P_STARVE_MAX`.
- Output register update each edge:
  - On any transfer, `o_regfile_rd_addr`/`_data` load the granted source's values.
  - On any transfer, `o_regfile_rd_wen` = (granted addr != 0).
  - With no transfer, `o_regfile_rd_wen` = 0 and addr/data hold their last values.
- x0 writes: the request is accepted (ready asserted, counter rules apply) but never produces `wen`.
- Same destination from both sources in the same cycle: writes land in grant order. With the default counter state, source 0 writes first and source 1 one cycle later, so the register ends with source 1's data.

## Timing
- Ready is same-cycle with valid: zero-cycle grant.
- A transfer at edge k puts the values on the output register after edge k. The regfile captures them at edge k+1. Regfile contents change one cycle after the handshake.
- Throughput: one write per cycle sustained. Both sources continuously valid gives a repeating pattern of `P_STARVE_MAX` source-0 grants followed by 1 source-1 grant.
- Reset values: `o_regfile_rd_wen`=0, `o_regfile_rd_addr`=0, `o_regfile_rd_data`=0, `starve_cnt`=0. Readies follow the combinational rules from that state.
- Reset mid-operation:
  - Assertion clears the output register immediately. A write registered but not yet captured by the regfile is dropped.
  - Sources whose handshake had not completed must re-present after release.
  - The first edge after deassertion behaves as a normal cycle.

## Structure
- `` `XLEN`` and the register-index width (5) come from the shared RV32I define header already included by the regfile.
- No package typedefs are needed.
- Single module, no sub-module. The starvation counter and output register are small enough to remain inline.
- Intended instantiation: directly in front of `riscv_regfile`, with `o_regfile_rd_*` wired to the regfile's `i_regfile_rd_*` ports.

## Test plan
- Reset and idle: with `i_rstn` low, then both valids low for 5 cycles, the bench must observe `o_regfile_rd_wen`=0, addr/data=0, and `o_starve_cnt`=0 throughout.
- Single source: source 0 writes x5=0x1234 at edge k. The bench must observe `o_wb0_ready`=1 during the request and `o_regfile_rd_wen`=1/addr 5/data 0x1234 after edge k, and regfile x5 must read 0x1234 after edge k+1.
- Contention: both sources continuously valid with distinct addrs, `P_STARVE_MAX`=3. Grants must be 0,0,0,1,0,0,0,1…, and `o_starve_cnt` must step 1,2,3,0.
- Same-address collision: source 0 writes x7=0xAAAA and source 1 writes x7=0x5555, both in the same cycle. Reading rs1=7 after both writes must return 0x5555.
- x0 discard: source 1 writes x0=0xFFFF_FFFF. The bench must observe `o_wb1_ready`=1 and `o_regfile_rd_wen` staying 0, and rs1=0 must read 0.
- Reset mid-op: assert `i_rstn` low between the handshake edge and the regfile capture edge. `o_regfile_rd_wen` must drop to 0 immediately and the target register must keep its old value.

Source files
------------

// File: rtl/riscv_regfile_wb_arb_pkg.sv
// rtl/riscv_regfile_wb_arb_pkg.sv - shared RV32I widths used by the regfile writeback arbiter
`ifndef XLEN
`define XLEN 32
`endif

package riscv_regfile_wb_arb_pkg;

  // Register index width of the RV32I integer register file (x0..x31)
  localparam int unsigned REGIDX_W = 5;

  // Starvation counter width; bounds the legal P_STARVE_MAX range
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/riscv_regfile_wb_arb.sv
// rtl/riscv_regfile_wb_arb.sv - two-source writeback arbiter in front of the RV32I regfile write port
`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile_wb_arb
  import riscv_regfile_wb_arb_pkg::*;
#(
  parameter int P_STARVE_MAX = 3
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_wb0_valid,
  output logic                o_wb0_ready,
  input  logic [REGIDX_W-1:0] i_wb0_addr,
  input  logic [`XLEN-1:0]    i_wb0_data,
  input  logic                i_wb1_valid,
  output logic                o_wb1_ready,
  input  logic [REGIDX_W-1:0] i_wb1_addr,
  input  logic [`XLEN-1:0]    i_wb1_data,
  output logic                o_regfile_rd_wen,
  output logic [REGIDX_W-1:0] o_regfile_rd_addr,
  output logic [`XLEN-1:0]    o_regfile_rd_data,
  output logic [STARVE_W-1:0] o_starve_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(P_STARVE_MAX);

  logic                starve_full;
  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic [REGIDX_W-1:0] sel_addr;
  logic [`XLEN-1:0]    sel_data;

  logic [STARVE_W-1:0] starve_cnt_d, starve_cnt_q;
  logic                wen_d, wen_q;
  logic [REGIDX_W-1:0] addr_d, addr_q;
  logic [`XLEN-1:0]    data_d, data_q;

  // Zero-cycle grant: source 0 wins unless source 1 has lost P_STARVE_MAX cycles in a row
  always_comb begin
    starve_full = (starve_cnt_q == STARVE_MAX);
    grant1      = i_wb1_valid && (!i_wb0_valid || starve_full);
    grant0      = i_wb0_valid && !grant1;
    xfer        = grant0 || grant1;
    sel_addr    = grant1 ? i_wb1_addr : i_wb0_addr;
    sel_data    = grant1 ? i_wb1_data : i_wb0_data;
  end

  // Next-state for the starvation counter and the write-port register
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wen_d        = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    // Counter only measures an unbroken run of losing cycles for source 1
    if (!i_wb1_valid || grant1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
    // x0 writes are accepted but never raise the regfile write enable
    if (xfer) begin
      wen_d  = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // State register; reset drops any write not yet captured by the regfile
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_cnt_q <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign o_wb0_ready       = grant0;
  assign o_wb1_ready       = grant1;
  assign o_regfile_rd_wen  = wen_q;
  assign o_regfile_rd_addr = addr_q;
  assign o_regfile_rd_data = data_q;
  assign o_starve_cnt      = starve_cnt_q;

endmodule

// File: tb/tb_riscv_regfile_wb_arb.sv
// tb/tb_riscv_regfile_wb_arb.sv - scoreboard bench for the regfile writeback arbiter
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_regfile_wb_arb;

  logic        i_clk;
  logic        i_rstn;
  logic        i_wb0_valid;
  logic        o_wb0_ready;
  logic [4:0]  i_wb0_addr;
  logic [31:0] i_wb0_data;
  logic        i_wb1_valid;
  logic        o_wb1_ready;
  logic [4:0]  i_wb1_addr;
  logic [31:0] i_wb1_data;
  logic        o_regfile_rd_wen;
  logic [4:0]  o_regfile_rd_addr;
  logic [31:0] o_regfile_rd_data;
  logic [3:0]  o_starve_cnt;

  riscv_regfile_wb_arb #(.P_STARVE_MAX(3)) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_wb0_valid       (i_wb0_valid),
    .o_wb0_ready       (o_wb0_ready),
    .i_wb0_addr        (i_wb0_addr),
    .i_wb0_data        (i_wb0_data),
    .i_wb1_valid       (i_wb1_valid),
    .o_wb1_ready       (o_wb1_ready),
    .i_wb1_addr        (i_wb1_addr),
    .i_wb1_data        (i_wb1_data),
    .o_regfile_rd_wen  (o_regfile_rd_wen),
    .o_regfile_rd_addr (o_regfile_rd_addr),
    .o_regfile_rd_data (o_regfile_rd_data),
    .o_starve_cnt      (o_starve_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Downstream regfile model: captures the write port one edge after the handshake
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(posedge i_clk) begin
    if (o_regfile_rd_wen) rf[o_regfile_rd_addr] <= o_regfile_rd_data;
  end

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : rf[a];
  endfunction

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_tests;
  int          n_fail;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;
  int          g0_cnt;
  int          g1_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive at edge+1, check readies mid-cycle, check register after the edge
  task automatic cyc(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic er0, input logic er1, input logic [3:0] ecnt,
                     input string tag);
    exp_t e;
    exp_t got;
    i_wb0_valid = v0; i_wb0_addr = a0; i_wb0_data = d0;
    i_wb1_valid = v1; i_wb1_addr = a1; i_wb1_data = d1;
    #2;
    chk({tag, ".rdy0"}, 32'(o_wb0_ready), 32'(er0));
    chk({tag, ".rdy1"}, 32'(o_wb1_ready), 32'(er1));
    if (er0) begin
      e = '{wen: (a0 != 5'd0), addr: a0, data: d0};
    end else if (er1) begin
      e = '{wen: (a1 != 5'd0), addr: a1, data: d1};
    end else begin
      e = '{wen: 1'b0, addr: hold_addr, data: hold_data};
    end
    hold_addr = e.addr;
    hold_data = e.data;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".wen"},  32'(o_regfile_rd_wen), 32'(got.wen));
      chk({tag, ".addr"}, 32'(o_regfile_rd_addr), 32'(got.addr));
      chk({tag, ".data"}, o_regfile_rd_data, got.data);
    end
    chk({tag, ".cnt"}, 32'(o_starve_cnt), 32'(ecnt));
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd0, tag);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    hold_addr = 5'd0; hold_data = 32'h0;
    i_rstn = 1'b0;
    i_wb0_valid = 1'b0; i_wb0_addr = 5'd0; i_wb0_data = 32'h0;
    i_wb1_valid = 1'b0; i_wb1_addr = 5'd0; i_wb1_data = 32'h0;

    // Reset held
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.wen",  32'(o_regfile_rd_wen), 32'd0);
    chk("rst.addr", 32'(o_regfile_rd_addr), 32'd0);
    chk("rst.data", o_regfile_rd_data, 32'h0);
    chk("rst.cnt",  32'(o_starve_cnt), 32'd0);
    i_rstn = 1'b1;

    // Idle after release
    for (int i = 0; i < 5; i++) idle("idle");

    // Single source 0 write, regfile sees it one edge later
    cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 4'd0, "single");
    chk("single.rf_before", rf_read(5'd5), 32'h0);
    idle("single_cap");
    chk("single.rf_x5", rf_read(5'd5), 32'h1234);

    // Contention: grants 0,0,0,1 repeating, counter 1,2,3,0
    g0_cnt = 0; g1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      logic gr1;
      logic [3:0] ec;
      gr1 = ((i % 4) == 3);
      ec  = gr1 ? 4'd0 : 4'((i % 4) + 1);
      cyc(1'b1, 5'd10, 32'h100 + 32'(g0_cnt), 1'b1, 5'd11, 32'hB00 + 32'(g1_cnt),
          !gr1, gr1, ec, "contend");
      if (gr1) g1_cnt++; else g0_cnt++;
    end
    idle("contend_end");
    chk("contend.rf_x10", rf_read(5'd10), 32'h105);
    chk("contend.rf_x11", rf_read(5'd11), 32'hB01);

    // Same-address collision: source 0 first, source 1 lands last
    cyc(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b1, 1'b0, 4'd1, "coll0");
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h5555, 1'b0, 1'b1, 4'd0, "coll1");
    chk("coll.rf_mid", rf_read(5'd7), 32'hAAAA);
    idle("coll_cap");
    chk("coll.rf_x7", rf_read(5'd7), 32'h5555);

    // x0 write is accepted but never enables the write port
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd0, "x0");
    idle("x0_cap");
    chk("x0.rf_x0", rf_read(5'd0), 32'h0);

    // Reset between the handshake edge and the regfile capture edge
    cyc(1'b1, 5'd9, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 4'd0, "pre9");
    idle("pre9_cap");
    chk("midrst.rf_old", rf_read(5'd9), 32'hDEAD);
    cyc(1'b1, 5'd9, 32'hBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 4'd0, "midrst");
    #1;
    i_rstn = 1'b0;
    i_wb0_valid = 1'b0;
    #1;
    chk("midrst.wen",  32'(o_regfile_rd_wen), 32'd0);
    chk("midrst.addr", 32'(o_regfile_rd_addr), 32'd0);
    chk("midrst.data", o_regfile_rd_data, 32'h0);
    @(posedge i_clk);
    #1;
    chk("midrst.rf_x9", rf_read(5'd9), 32'hDEAD);
    i_rstn = 1'b1;
    hold_addr = 5'd0;
    hold_data = 32'h0;

    // First cycle after release is a normal transfer
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b1, 4'd0, "post");
    idle("post_cap");
    chk("post.rf_x3", rf_read(5'd3), 32'h33);
    chk("post.rf_x9", rf_read(5'd9), 32'hDEAD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
